// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding and grant identifiers for mem_arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic GRANT_M0 = 1'b0;
    localparam logic GRANT_M1 = 1'b1;

endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - saturating wait-cycle counter that flags an unacknowledged transaction
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT     = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST_STEP = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_en && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires in the cycle whose increment would reach TIMEOUT, so the abort lands on that edge.
    assign expired = (TIMEOUT != 0) && count_en && (r_count == LAST_STEP);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-requester arbiter onto one picorv32-style memory port
module mem_arbiter #(
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err
);

    import mem_arbiter_pkg::*;

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic        r_grant;
    logic        r_last_grant;
    logic        r_mem_valid;
    logic        r_mem_instr;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic        r_m0_ready;
    logic        r_m1_ready;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;
    logic        r_timeout_err;

    logic        w_any_req;
    logic        w_sel;
    logic        w_wd_clear;
    logic        w_wd_count;
    logic        w_expired;

    assign w_any_req = m0_valid | m1_valid;
    // On a tie the requester that did not win last time goes first.
    assign w_sel     = (m0_valid && m1_valid) ? ~r_last_grant : m1_valid;

    assign w_wd_clear = (r_state == IDLE);
    assign w_wd_count = (r_state == BUSY) && !mem_ready;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_wd_clear),
        .count_en (w_wd_count),
        .expired  (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next_state = BUSY;
            BUSY:    if (mem_ready || w_expired) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant       <= GRANT_M0;
            r_last_grant  <= GRANT_M1;
            r_mem_valid   <= 1'b0;
            r_mem_instr   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_wstrb   <= '0;
            r_m0_ready    <= 1'b0;
            r_m1_ready    <= 1'b0;
            r_m0_rdata    <= '0;
            r_m1_rdata    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_m0_ready <= 1'b0;
            r_m1_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant      <= w_sel;
                        r_last_grant <= w_sel;
                        r_mem_valid  <= 1'b1;
                        r_mem_instr  <= (w_sel == GRANT_M1) ? m1_instr : m0_instr;
                        r_mem_addr   <= (w_sel == GRANT_M1) ? m1_addr  : m0_addr;
                        r_mem_wdata  <= (w_sel == GRANT_M1) ? m1_wdata : m0_wdata;
                        r_mem_wstrb  <= (w_sel == GRANT_M1) ? m1_wstrb : m0_wstrb;
                    end
                end
                BUSY: begin
                    // A late ack in the expiry cycle still wins over the abort.
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        if (r_grant == GRANT_M1) begin
                            r_m1_ready <= 1'b1;
                            if (r_mem_wstrb == 4'b0000) r_m1_rdata <= mem_rdata;
                        end else begin
                            r_m0_ready <= 1'b1;
                            if (r_mem_wstrb == 4'b0000) r_m0_rdata <= mem_rdata;
                        end
                    end else if (w_expired) begin
                        r_mem_valid   <= 1'b0;
                        r_timeout_err <= 1'b1;
                        if (r_grant == GRANT_M1) begin
                            r_m1_ready <= 1'b1;
                            r_m1_rdata <= ERR_RDATA;
                        end else begin
                            r_m0_ready <= 1'b1;
                            r_m0_rdata <= ERR_RDATA;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_valid   = r_mem_valid;
    assign mem_instr   = r_mem_instr;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_wstrb   = r_mem_wstrb;
    assign m0_ready    = r_m0_ready;
    assign m1_ready    = r_m1_ready;
    assign m0_rdata    = r_m0_rdata;
    assign m1_rdata    = r_m1_rdata;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - transaction-level checks of mem_arbiter against a round-robin reference model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_valid, m1_valid, m0_instr, m1_instr;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        timeout_err;

    logic        d4_m0_ready, d4_m1_ready, d4_mem_valid, d4_mem_instr, d4_timeout_err;
    logic [31:0] d4_m0_rdata, d4_m1_rdata, d4_mem_addr, d4_mem_wdata;
    logic [3:0]  d4_mem_wstrb;

    localparam int T8 = 8;

    mem_arbiter #(.TIMEOUT(T8), .ERR_RDATA(32'hFFFF_FFFF)) u_dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    mem_arbiter #(.TIMEOUT(4), .ERR_RDATA(32'hFFFF_FFFF)) u_dut4 (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(d4_m0_ready), .m0_rdata(d4_m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(d4_m1_ready), .m1_rdata(d4_m1_rdata),
        .mem_valid(d4_mem_valid), .mem_instr(d4_mem_instr), .mem_ready(mem_ready), .mem_addr(d4_mem_addr),
        .mem_wdata(d4_mem_wdata), .mem_wstrb(d4_mem_wstrb), .mem_rdata(mem_rdata),
        .timeout_err(d4_timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending requests per requester, expected held rdata, round-robin memory
    bit          pend [2];
    logic [31:0] q_addr [2];
    logic [31:0] q_wdata [2];
    logic [3:0]  q_wstrb [2];
    bit          q_instr [2];
    logic [31:0] exp_rdata [2];
    int          last_g;
    bit          exp_err;
    logic [31:0] got_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        m0_valid = pend[0]; m0_addr = q_addr[0]; m0_wdata = q_wdata[0];
        m0_wstrb = q_wstrb[0]; m0_instr = q_instr[0];
        m1_valid = pend[1]; m1_addr = q_addr[1]; m1_wdata = q_wdata[1];
        m1_wstrb = q_wstrb[1]; m1_instr = q_instr[1];
    endtask

    task automatic new_req(input int i);
        q_addr[i]  = {(i == 1) ? 4'h8 : 4'h0, 26'($urandom), 2'b00};
        q_wdata[i] = $urandom;
        q_wstrb[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        q_instr[i] = ($urandom_range(0, 1) == 1);
        pend[i]    = 1'b1;
    endtask

    function automatic int pick(bit p0, bit p1, int last);
        if (p0 && p1) return 1 - last;
        return p1 ? 1 : 0;
    endfunction

    function automatic logic rdy(int i);
        return (i == 1) ? m1_ready : m0_ready;
    endfunction

    task automatic model_reset();
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        last_g = 1;
        exp_err = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive();
        mem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // One whole transaction: wait for the grant, check the forwarded request, respond, check the pulse.
    task automatic do_txn(input int waits, input logic [31:0] rd, input bit never_ack, input string tag);
        int w;
        int n;
        w = pick(pend[0], pend[1], last_g);
        n = 0;
        while (mem_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk({tag, ":latency"}, 32'(n), 32'd1);
        got_addr = mem_addr;
        chk({tag, ":addr"},  mem_addr, q_addr[w]);
        chk({tag, ":wdata"}, mem_wdata, q_wdata[w]);
        chk({tag, ":wstrb"}, {28'b0, mem_wstrb}, {28'b0, q_wstrb[w]});
        chk({tag, ":instr"}, 32'(mem_instr), 32'(q_instr[w]));
        if (never_ack) begin
            n = 0;
            while (n < 50) begin
                mem_rdata = $urandom;
                tick();
                n++;
                if (mem_valid !== 1'b1) break;
            end
            chk({tag, ":busy_cycles"}, 32'(n), 32'(T8));
            exp_rdata[w] = 32'hFFFF_FFFF;
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < waits; i++) begin
                mem_rdata = $urandom;
                tick();
                chk({tag, ":hold_valid"}, 32'(mem_valid), 32'd1);
                chk({tag, ":hold_addr"}, mem_addr, got_addr);
                chk({tag, ":no_early_rdy"}, {30'b0, m1_ready, m0_ready}, 32'd0);
            end
            mem_ready = 1'b1;
            mem_rdata = rd;
            tick();
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (q_wstrb[w] == 4'h0) exp_rdata[w] = rd;
        end
        last_g = w;
        chk({tag, ":rdy_win"},   32'(rdy(w)), 32'd1);
        chk({tag, ":rdy_lose"},  32'(rdy(1 - w)), 32'd0);
        chk({tag, ":valid_off"}, 32'(mem_valid), 32'd0);
        chk({tag, ":rdata0"},    m0_rdata, exp_rdata[0]);
        chk({tag, ":rdata1"},    m1_rdata, exp_rdata[1]);
        chk({tag, ":terr"},      32'(timeout_err), 32'(exp_err));
        pend[w] = 1'b0;
        drive();
        tick();
        chk({tag, ":rdy_1cyc"}, {30'b0, m1_ready, m0_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1);
    end

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; q_addr[i] = '0; q_wdata[i] = '0; q_wstrb[i] = '0; q_instr[i] = 1'b0;
        end
        drive();
        model_reset();
        #1;
        reset = 1'b1;
        #1;
        chk("rst:mem_valid", 32'(mem_valid), 32'd0);
        chk("rst:mem_addr", mem_addr, 32'd0);
        chk("rst:mem_wdata", mem_wdata, 32'd0);
        chk("rst:mem_misc", {27'b0, mem_instr, mem_wstrb}, 32'd0);
        chk("rst:ready", {30'b0, m1_ready, m0_ready}, 32'd0);
        chk("rst:rdata0", m0_rdata, 32'd0);
        chk("rst:rdata1", m1_rdata, 32'd0);
        chk("rst:terr", 32'(timeout_err), 32'd0);
        tick();
        reset = 1'b0;

        // m0 reads 0x100 alone with two wait states
        pend[0] = 1'b1; q_addr[0] = 32'h100; q_wdata[0] = $urandom; q_wstrb[0] = 4'h0; q_instr[0] = 1'b0;
        drive();
        do_txn(2, 32'hDEAD_BEEF, 1'b0, "rd0");
        chk("rd0:data", m0_rdata, 32'hDEAD_BEEF);

        // both requesting from reset, each re-requesting at once
        do_reset();
        new_req(0); new_req(1);
        drive();
        for (int k = 0; k < 4; k++) begin
            do_txn(1, $urandom, 1'b0, "tie");
            chk("tie:order", {31'b0, got_addr[31]}, 32'(k % 2));
            for (int i = 0; i < 2; i++) if (!pend[i]) new_req(i);
            drive();
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive();
        tick();
        tick();

        // m1 byte write
        pend[1] = 1'b1; q_addr[1] = 32'h204; q_wdata[1] = 32'hA5; q_wstrb[1] = 4'b0010; q_instr[1] = 1'b0;
        drive();
        do_txn(0, 32'h1357_9BDF, 1'b0, "wr1");

        // randomized mix of reads/writes, overlapping requests and wait states
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 2; i++) if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
            if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
            drive();
            do_txn(int'($urandom_range(0, 5)), $urandom, 1'b0, "rnd");
        end
        for (int i = 0; i < 2; i++) pend[i] = 1'b0;
        drive();

        // memory never acknowledges; flag stays set through a normal transaction
        new_req(0);
        q_wstrb[0] = 4'h0;
        drive();
        do_txn(0, 32'h0, 1'b1, "tmo");
        chk("tmo:data", m0_rdata, 32'hFFFF_FFFF);
        new_req(1);
        drive();
        do_txn(2, $urandom, 1'b0, "post_tmo");
        chk("post_tmo:sticky", 32'(timeout_err), 32'd1);

        // reset in the middle of BUSY
        new_req(0);
        drive();
        tick();
        chk("mid_rst:busy", 32'(mem_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst:valid_drop", 32'(mem_valid), 32'd0);
        chk("mid_rst:terr", 32'(timeout_err), 32'd0);
        tick();
        chk("mid_rst:no_rdy", {30'b0, m1_ready, m0_ready}, 32'd0);
        reset = 1'b0;
        model_reset();
        new_req(1);
        drive();
        do_txn(1, $urandom, 1'b0, "rst_tie");
        chk("rst_tie:m0_first", {31'b0, got_addr[31]}, 32'd0);
        for (int i = 0; i < 2; i++) pend[i] = 1'b0;
        drive();

        // TIMEOUT=4 instance: ack on the 4th low cycle completes normally, one later aborts
        do_reset();
        new_req(0);
        q_wstrb[0] = 4'h0;
        drive();
        do_txn(3, 32'h1234_5678, 1'b0, "t4_edge");
        chk("t4_edge:data", d4_m0_rdata, 32'h1234_5678);
        chk("t4_edge:terr", 32'(d4_timeout_err), 32'd0);
        new_req(0);
        q_wstrb[0] = 4'h0;
        drive();
        do_txn(4, 32'h0BAD_CAFE, 1'b0, "t4_over");
        chk("t4_over:data", d4_m0_rdata, 32'hFFFF_FFFF);
        chk("t4_over:terr", 32'(d4_timeout_err), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single picorv32-style memory port (valid/instr/ready/addr/wdata/wstrb/rdata).
- Requester 0 is the CPU core; requester 1 is a secondary master (debug loader or DMA).
- Grants one whole transaction at a time using round-robin priority, and forwards the response to the granted requester only.
- A watchdog aborts transactions the memory never acknowledges.

Parameters:
- TIMEOUT, 255: cycles in BUSY with mem_ready low before abort; 0 disables the watchdog.
- ERR_RDATA, 32'hFFFF_FFFF: rdata returned to the requester on an aborted transaction.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- m0_valid / m1_valid  input  1  requester n has a transaction pending
- m0_instr / m1_instr  input  1  requester n access is an instruction fetch
- m0_addr / m1_addr  input  32  requester n address
- m0_wdata / m1_wdata  input  32  requester n write data
- m0_wstrb / m1_wstrb  input  4  requester n byte strobes; 0 means read
- m0_ready / m1_ready  output  1  one-cycle completion pulse to requester n
- m0_rdata / m1_rdata  output  32  registered read data for requester n
- mem_valid  output  1  downstream request valid
- mem_instr  output  1  downstream instruction-fetch flag
- mem_ready  input  1  downstream acknowledge
- mem_addr  output  32  downstream address
- mem_wdata  output  32  downstream write data
- mem_wstrb  output  4  downstream byte strobes
- mem_rdata  input  32  downstream read data
- timeout_err  output  1  sticky flag: a watchdog abort has occurred

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0 immediately.
  - State = IDLE, last_grant = 1 (so requester 0 wins the first tie), watchdog count = 0.
  - A reset during BUSY drops mem_valid at once; no ready pulse is issued for the aborted transaction.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Requests are sampled at each rising edge.
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - On grant, register the winner's addr/wdata/wstrb/instr onto mem_*, set mem_valid=1, record grant and last_grant, clear the watchdog, go to BUSY.
  - Latency: mem_valid is high in the cycle after the request is first sampled.
- BUSY:
  - mem_* stay stable while mem_valid=1.
  - mem_ready=1: mem_valid<=0; granted mN_rdata<=mem_rdata for reads, unchanged for writes; go to DONE.
  - mem_ready=0: increment the watchdog.
  - Watchdog reaches TIMEOUT (TIMEOUT≠0): mem_valid<=0, granted mN_rdata<=ERR_RDATA, timeout_err<=1, go to DONE.
  - mem_ready arriving in the same cycle as expiry counts as a normal completion; no error.
- DONE:
  - Granted mN_ready=1 for exactly this cycle; the other requester's ready stays 0.
  - Next state is always IDLE.
  - The one-cycle DONE bubble guarantees a requester that clears valid on seeing ready is not re-granted.
- Ready and rdata are registered outputs. mN_rdata holds its value until that requester's next completed read.
- A requester dropping valid while granted is a protocol violation. The transaction still completes and the ready pulse is still issued.
- Minimum back-to-back throughput: one transaction per 3 cycles (IDLE→BUSY→DONE), assuming zero-wait memory.
- The watchdog counter is sized to $clog2(TIMEOUT+1) bits and does not wrap: it holds at TIMEOUT until the state leaves BUSY.
- timeout_err is cleared only by reset.

Decomposition:
- Package mem_arbiter_pkg: the arb_state_t enum (IDLE, BUSY, DONE) and the constants GRANT_M0=0 and GRANT_M1=1.
- Sub-module arb_watchdog holds the counter:
  - Inputs: clk, reset, clear, count_en.
  - Output: expired.
  - Parameter: TIMEOUT.
- Grant selection and the mux stay inline.

Test Plan:
- m0 reads 0x100 alone; memory acks after 2 wait cycles with 0xDEADBEEF → mem_addr=0x100, mem_wstrb=0; one m0_ready pulse with m0_rdata=0xDEADBEEF; m1_ready stays 0.
- m0 and m1 both valid from reset, each re-requesting immediately → grant order m0, m1, m0, m1; mem_addr alternates; no requester is starved.
- m1 writes 0xA5 with wstrb=4'b0010 to 0x204 → mem_wdata/mem_wstrb/mem_addr match exactly and mem_instr=0; m1_ready pulses; m1_rdata unchanged.
- TIMEOUT=8, memory never acks → mem_valid drops after 8 BUSY cycles; m0_ready pulses with m0_rdata=0xFFFFFFFF; timeout_err=1 and stays high through the next normal transaction.
- Assert reset mid-BUSY → mem_valid=0 immediately; no ready pulse; after reset release, a tie grants m0 first.
- mem_ready arrives in the same cycle the watchdog expires (TIMEOUT=4, ack on the 4th cycle) → normal data returned; timeout_err stays 0.
